// File: rtl/buzzer_pkg.sv
// Shared types and the stored note patterns for the buzzer sequencer.
package buzzer_pkg;

    typedef enum logic [2:0] {MUTE, DO, RE, MI, PA, SOL, RA, SI} tone_e;

    typedef struct packed {
        tone_e      tone;
        logic [3:0] dur;
        logic       last;
    } step_t;

    typedef enum logic [1:0] {IDLE, NOTE, REST} state_e;

    localparam int unsigned PAT_W  = 2;
    localparam int unsigned STEP_W = 3;
    localparam int unsigned DCNT_W = 8;

    localparam step_t FILL = '{MUTE, 4'd0, 1'b1};

    // 0=key beep, 1=alarm (8 steps, relies on step 7 ending it), 2=win jingle, 3=error
    localparam step_t PATTERN_ROM [4][8] = '{
        '{'{DO, 4'd3, 1'b1}, FILL, FILL, FILL, FILL, FILL, FILL, FILL},
        '{'{RA, 4'd2, 1'b0}, '{MI, 4'd2, 1'b0}, '{RA, 4'd2, 1'b0}, '{MI, 4'd2, 1'b0},
          '{RA, 4'd2, 1'b0}, '{MI, 4'd2, 1'b0}, '{RA, 4'd2, 1'b0}, '{MI, 4'd2, 1'b0}},
        '{'{DO, 4'd1, 1'b0}, '{MI, 4'd1, 1'b0}, '{SOL, 4'd2, 1'b0}, '{SI, 4'd4, 1'b1},
          FILL, FILL, FILL, FILL},
        '{'{SI, 4'd0, 1'b0}, '{MUTE, 4'd2, 1'b0}, '{RE, 4'd3, 1'b1},
          FILL, FILL, FILL, FILL, FILL}
    };

endpackage

// File: rtl/buzzer_tick_gen.sv
// Restartable divider: one-cycle tick every TICK_CYCLES clocks, re-phased by restart.
module buzzer_tick_gen #(
    parameter int unsigned TICK_CYCLES = 100_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick_c
);
    localparam int unsigned CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (restart || (cnt_q == CNT_LAST)) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign tick_c = (cnt_q == CNT_LAST);

endmodule

// File: rtl/buzzer_sequencer.sv
// Shares one tone generator between prioritised requesters, each playing a stored
// note pattern with a muted gap after every note; optional preemption.
module buzzer_sequencer
    import buzzer_pkg::*;
#(
    parameter int unsigned N_REQ       = 3,
    parameter int unsigned TICK_CYCLES = 100_000,
    parameter int unsigned REST_TICKS  = 20,
    parameter int unsigned PREEMPT     = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_i,
    input  logic [N_REQ*2-1:0] pat_id_i,
    output logic [N_REQ-1:0]   grant_o,
    output logic [2:0]         tone_sel_o,
    output logic               busy_o,
    output logic [N_REQ-1:0]   done_o,
    output logic [N_REQ-1:0]   abort_o
);
    localparam int unsigned OWN_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    if ((REST_TICKS < 1) || (REST_TICKS > 255)) begin : g_bad_rest
        $error("REST_TICKS must be in 1..255");
    end

    state_e              state_q, state_d;
    logic [OWN_W-1:0]    owner_q, owner_d;
    logic [PAT_W-1:0]    pat_q, pat_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [DCNT_W-1:0]   dcnt_q, dcnt_d;
    logic [N_REQ-1:0]    pend_q;
    logic [PAT_W-1:0]    pat_id_q [N_REQ];

    logic [OWN_W-1:0]    win_c;
    logic                win_valid_c;
    logic                take_c, enter_c, done_c, abort_c;
    logic                tick_c, dur_done_c, last_step_c;
    logic [DCNT_W-1:0]   target_c;
    step_t               cur_step, next_step;

    logic [N_REQ-1:0]    grant_d, done_d, abort_d;
    logic [2:0]          tone_d;
    logic                busy_d;

    buzzer_tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (enter_c),
        .tick_c  (tick_c)
    );

    // Pending requests: a new request wins over the clear from being granted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
            for (int k = 0; k < N_REQ; k++) pat_id_q[k] <= '0;
        end else begin
            for (int k = 0; k < N_REQ; k++) begin
                if (req_i[k]) begin
                    pend_q[k]   <= 1'b1;
                    pat_id_q[k] <= pat_id_i[2*k +: 2];
                end else if (take_c && (win_c == OWN_W'(k))) begin
                    pend_q[k] <= 1'b0;
                end
            end
        end
    end

    // Fixed priority: lowest pending index wins
    always_comb begin
        win_c       = '0;
        win_valid_c = |pend_q;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (pend_q[k]) win_c = OWN_W'(k);
        end
    end

    assign cur_step    = PATTERN_ROM[pat_q][step_q];
    assign last_step_c = cur_step.last | (step_q == STEP_W'(7));
    assign target_c    = (state_q == NOTE)
                         ? ((cur_step.dur == 4'd0) ? DCNT_W'(1) : {4'd0, cur_step.dur})
                         : DCNT_W'(REST_TICKS);
    assign dur_done_c  = tick_c && ((dcnt_q + DCNT_W'(1)) == target_c);

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            pat_q      <= '0;
            step_q     <= '0;
            dcnt_q     <= '0;
            grant_o    <= '0;
            tone_sel_o <= '0;
            busy_o     <= 1'b0;
            done_o     <= '0;
            abort_o    <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            pat_q      <= pat_d;
            step_q     <= step_d;
            dcnt_q     <= dcnt_d;
            grant_o    <= grant_d;
            tone_sel_o <= tone_d;
            busy_o     <= busy_d;
            done_o     <= done_d;
            abort_o    <= abort_d;
        end
    end

    // Next state: preemption is checked before step/pattern completion
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        pat_d   = pat_q;
        step_d  = step_q;
        dcnt_d  = dcnt_q;
        take_c  = 1'b0;
        enter_c = 1'b0;
        done_c  = 1'b0;
        abort_c = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (win_valid_c) take_c = 1'b1;
            end
            NOTE, REST: begin
                if ((PREEMPT != 0) && win_valid_c && (win_c < owner_q)) begin
                    abort_c = 1'b1;
                    take_c  = 1'b1;
                end else if (dur_done_c) begin
                    enter_c = 1'b1;
                    if (state_q == NOTE) begin
                        state_d = REST;
                    end else if (!last_step_c) begin
                        state_d = NOTE;
                        step_d  = step_q + STEP_W'(1);
                    end else begin
                        done_c  = 1'b1;
                        state_d = IDLE;
                        take_c  = win_valid_c;
                    end
                end else if (tick_c) begin
                    dcnt_d = dcnt_q + DCNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        if (take_c) begin
            state_d = NOTE;
            owner_d = win_c;
            pat_d   = pat_id_q[win_c];
            step_d  = '0;
            enter_c = 1'b1;
        end
        if (enter_c) dcnt_d = '0;
    end

    assign next_step = PATTERN_ROM[pat_d][step_d];

    // Output values for the coming cycle
    always_comb begin
        busy_d  = (state_d != IDLE);
        tone_d  = (state_d == NOTE) ? 3'(next_step.tone) : 3'd0;
        grant_d = '0;
        done_d  = '0;
        abort_d = '0;
        for (int k = 0; k < N_REQ; k++) begin
            grant_d[k] = busy_d && (owner_d == OWN_W'(k));
            done_d[k]  = done_c && (owner_q == OWN_W'(k));
            abort_d[k] = abort_c && (owner_q == OWN_W'(k));
        end
    end

endmodule
